joy_dial_multi: RTL and testbench



---
 rtl/joy_dial_pkg.sv | 42 ++++
 rtl/joy_dial_chan.sv | 143 ++++++++++++++
 rtl/joy_dial_multi.sv | 46 ++++
 tb/tb_joy_dial_multi.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_dial_pkg.sv
// Shared types and helpers for the multi-channel dial mapper: mode and
// direction enums, the idle dial code and the Gray phase encoder.
package joy_dial_pkg;

  typedef enum logic {
    DIAL_LEVEL = 1'b0,
    DIAL_QUAD  = 1'b1
  } dial_mode_e;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dial_dir_e;

  localparam logic [1:0] DIAL_IDLE = 2'b11;

  // Active-low Gray sequence: 0 -> 11, 1 -> 10, 2 -> 00, 3 -> 01.
  function automatic logic [1:0] gray2(input logic [1:0] idx);
    return ~(idx ^ {1'b0, idx[1]});
  endfunction

  // Opposing buttons cancel; invert swaps the sense after cancellation.
  function automatic dial_dir_e resolve_dir(input logic up, input logic down,
                                            input logic invert);
    logic u;
    logic d;
    u = up & ~down;
    d = down & ~up;
    if (invert) begin
      {u, d} = {d, u};
    end
    if (u) begin
      return DIR_UP;
    end
    if (d) begin
      return DIR_DN;
    end
    return DIR_IDLE;
  endfunction

endpackage

// File: rtl/joy_dial_chan.sv
// One dial channel: direction resolution, step-rate counter with hold
// acceleration, saturating spinner accumulator, phase and output registers.
module joy_dial_chan
  import joy_dial_pkg::*;
#(
  parameter int RATE_W      = 16,
  parameter int DELTA_W     = 8,
  parameter int ACC_W       = 10,
  parameter int ACCEL_STEPS = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mode_i,
  input  logic               invert_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic [DELTA_W-1:0] delta_i,
  input  logic               delta_stb_i,
  input  logic [RATE_W-1:0]  period_base_i,
  output logic [1:0]         dial_o,
  output logic               moving_o
);

  localparam int HOLD_W = $clog2(ACCEL_STEPS + 1);
  localparam int SUM_W  = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX  = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN  = SUM_W'(-(2 ** (ACC_W - 1)));
  localparam logic [HOLD_W-1:0]       HOLD_MAX = HOLD_W'(ACCEL_STEPS);

  dial_mode_e               mode_q;
  dial_dir_e                dir_q;
  logic [1:0]               phase_q, phase_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [RATE_W-1:0]        cnt_q, cnt_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [1:0]               dial_q, dial_d;
  logic                     moving_q, moving_d;

  dial_mode_e               mode;
  dial_dir_e                dir;
  logic [RATE_W-1:0]        base_p, fast_p;
  logic signed [SUM_W-1:0]  acc_ext, delta_ext, sum;
  logic [HOLD_W-1:0]        hold_n;
  logic                     press, step_up, step_dn;

  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v > ACC_MAX) begin
      return ACC_MAX[ACC_W-1:0];
    end
    if (v < ACC_MIN) begin
      return ACC_MIN[ACC_W-1:0];
    end
    return v[ACC_W-1:0];
  endfunction

  assign mode  = dial_mode_e'(mode_i);
  assign dir   = resolve_dir(up_i, down_i, invert_i);
  assign press = (dir != DIR_IDLE) && (dir != dir_q);

  // A zero period would stall the counter, so both rates floor at one cycle.
  assign base_p = (period_base_i == '0) ? RATE_W'(1) : period_base_i;
  assign fast_p = (period_base_i[RATE_W-1:1] == '0) ? RATE_W'(1)
                                                    : {1'b0, period_base_i[RATE_W-1:1]};

  assign acc_ext   = {{(SUM_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign delta_ext = delta_stb_i ? {{(SUM_W - DELTA_W){delta_i[DELTA_W-1]}}, delta_i}
                                 : '0;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no branch can infer a latch.
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    hold_n  = hold_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    sum     = acc_ext + delta_ext;

    if ((mode != mode_q) || (mode == DIAL_LEVEL)) begin
      acc_d  = '0;
      cnt_d  = '0;
      hold_d = '0;
    end else if (dir != DIR_IDLE) begin
      // Held direction wins: strobes still accumulate but nothing drains.
      acc_d = saturate(sum);
      if (press || (cnt_q == '0)) begin
        if (press) begin
          hold_n = HOLD_W'(1);
        end else if (hold_q != HOLD_MAX) begin
          hold_n = hold_q + HOLD_W'(1);
        end
        hold_d  = hold_n;
        step_up = (dir == DIR_UP);
        step_dn = (dir == DIR_DN);
        cnt_d   = ((hold_n >= HOLD_MAX) ? fast_p : base_p) - RATE_W'(1);
      end else begin
        cnt_d = cnt_q - RATE_W'(1);
      end
    end else begin
      hold_d = '0;
      if ((acc_q != '0) && (cnt_q == '0)) begin
        step_dn = acc_q[ACC_W-1];
        step_up = ~acc_q[ACC_W-1];
        sum     = step_dn ? sum + SUM_W'(1) : sum - SUM_W'(1);
        cnt_d   = base_p - RATE_W'(1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - RATE_W'(1);
      end
      acc_d = saturate(sum);
    end

    phase_d  = phase_q + 2'(step_up) - 2'(step_dn);
    dial_d   = (mode == DIAL_QUAD) ? gray2(phase_d) : {dir != DIR_DN, dir != DIR_UP};
    moving_d = step_up | step_dn | (dir != DIR_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= DIAL_LEVEL;
      dir_q    <= DIR_IDLE;
      phase_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      dial_q   <= DIAL_IDLE;
      moving_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      mode_q   <= mode;
      dir_q    <= dir;
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      dial_q   <= dial_d;
      moving_q <= moving_d;
    end
  end

  assign dial_o   = dial_q;
  assign moving_o = moving_q;

endmodule

// File: rtl/joy_dial_multi.sv
// Multi-channel dial mapper: one joy_dial_chan per player, with the packed
// delta and dial buses sliced per channel.
module joy_dial_multi
  import joy_dial_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int RATE_W      = 16,
  parameter int DELTA_W     = 8,
  parameter int ACC_W       = 10,
  parameter int ACCEL_STEPS = 8
) (
  input  logic                        clk_sys,
  input  logic                        reset_n,
  input  logic [CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]         invert,
  input  logic [CHANNELS-1:0]         up,
  input  logic [CHANNELS-1:0]         down,
  input  logic [CHANNELS*DELTA_W-1:0] delta,
  input  logic [CHANNELS-1:0]         delta_stb,
  input  logic [RATE_W-1:0]           period_base,
  output logic [2*CHANNELS-1:0]       dial_out,
  output logic [CHANNELS-1:0]         moving
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    joy_dial_chan #(
      .RATE_W      (RATE_W),
      .DELTA_W     (DELTA_W),
      .ACC_W       (ACC_W),
      .ACCEL_STEPS (ACCEL_STEPS)
    ) u_chan (
      .clk_i         (clk_sys),
      .rst_ni        (reset_n),
      .mode_i        (mode[c]),
      .invert_i      (invert[c]),
      .up_i          (up[c]),
      .down_i        (down[c]),
      .delta_i       (delta[c*DELTA_W +: DELTA_W]),
      .delta_stb_i   (delta_stb[c]),
      .period_base_i (period_base),
      .dial_o        (dial_out[2*c +: 2]),
      .moving_o      (moving[c])
    );
  end

endmodule

// File: tb/tb_joy_dial_multi.sv
// Bench for joy_dial_multi: level-mode vector table, directed quadrature,
// drain, saturation, priority and reset sequences, then random stimulus.
module tb_joy_dial_multi;

  localparam int CH      = 2;
  localparam int RATE_W  = 16;
  localparam int DELTA_W = 8;
  localparam int ACC_W   = 10;
  localparam int ACCEL   = 8;
  localparam int ACC_HI  = 511;
  localparam int ACC_LO  = -512;

  logic                  clk_sys = 1'b0;
  logic                  reset_n;
  logic [CH-1:0]         mode, invert, up, down, delta_stb;
  logic [CH*DELTA_W-1:0] delta;
  logic [RATE_W-1:0]     period_base;
  logic [2*CH-1:0]       dial_out;
  logic [CH-1:0]         moving;

  joy_dial_multi #(
    .CHANNELS (CH), .RATE_W (RATE_W), .DELTA_W (DELTA_W),
    .ACC_W (ACC_W), .ACCEL_STEPS (ACCEL)
  ) dut (
    .clk_sys (clk_sys), .reset_n (reset_n), .mode (mode), .invert (invert),
    .up (up), .down (down), .delta (delta), .delta_stb (delta_stb),
    .period_base (period_base), .dial_out (dial_out), .moving (moving)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int phase;     // 0..3
    int acc;       // signed integer, clamped
    int wait_cnt;  // cycles left before the next timed step is allowed
    int held;      // consecutive held steps
    int last_dir;  // -1, 0, +1
    int last_mode;
    int code;
    int mov;
  } ref_t;

  ref_t m[CH];
  int   gray_tab[4] = '{3, 2, 0, 1};

  function automatic int clamp(input int v);
    if (v > ACC_HI) return ACC_HI;
    if (v < ACC_LO) return ACC_LO;
    return v;
  endfunction

  function automatic int period_for(input int held);
    int pb;
    pb = int'(period_base);
    if (held >= ACCEL) return ((pb / 2) < 1) ? 1 : pb / 2;
    return (pb < 1) ? 1 : pb;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) m[c] = '{0, 0, 0, 0, 0, 0, 3, 0};
  endfunction

  function automatic void model_edge();
    for (int c = 0; c < CH; c++) begin
      int dir, md, dl, stepv;
      logic signed [DELTA_W-1:0] ds;
      dir = 0;
      if (up[c] && !down[c]) dir = 1;
      if (down[c] && !up[c]) dir = -1;
      if (invert[c]) dir = -dir;
      md = int'(mode[c]);
      ds = delta[c*DELTA_W +: DELTA_W];
      dl = delta_stb[c] ? int'(ds) : 0;
      stepv = 0;
      if (md != m[c].last_mode || md == 0) begin
        m[c].acc = 0; m[c].wait_cnt = 0; m[c].held = 0;
      end else if (dir != 0) begin
        m[c].acc = clamp(m[c].acc + dl);
        if (dir != m[c].last_dir) begin
          m[c].held = 1;
          stepv = dir;
          m[c].wait_cnt = period_for(m[c].held) - 1;
        end else if (m[c].wait_cnt == 0) begin
          m[c].held = (m[c].held + 1 > ACCEL) ? ACCEL : m[c].held + 1;
          stepv = dir;
          m[c].wait_cnt = period_for(m[c].held) - 1;
        end else begin
          m[c].wait_cnt--;
        end
      end else begin
        m[c].held = 0;
        if (m[c].acc != 0 && m[c].wait_cnt == 0) begin
          stepv = (m[c].acc > 0) ? 1 : -1;
          m[c].acc = clamp(m[c].acc + dl - stepv);
          m[c].wait_cnt = period_for(0) - 1;
        end else begin
          m[c].acc = clamp(m[c].acc + dl);
          if (m[c].wait_cnt > 0) m[c].wait_cnt--;
        end
      end
      m[c].phase = (m[c].phase + stepv + 4) % 4;
      if (md == 1) m[c].code = gray_tab[m[c].phase];
      else m[c].code = (dir == 1) ? 2 : (dir == -1) ? 1 : 3;
      m[c].mov = (stepv != 0 || dir != 0) ? 1 : 0;
      m[c].last_dir = dir;
      m[c].last_mode = md;
    end
  endfunction

  // One clock: model advances on the edge, DUT outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk_sys);
    if (reset_n) model_edge();
    #1;
    for (int c = 0; c < CH; c++) begin
      check($sformatf("model dial ch%0d", c), 32'(dial_out[2*c +: 2]), 32'(m[c].code));
      check($sformatf("model moving ch%0d", c), 32'(moving[c]), 32'(m[c].mov));
    end
  endtask

  function automatic int code_idx(input logic [1:0] code);
    case (code)
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  typedef struct {
    logic       u, d, inv;
    logic [1:0] dial;
    logic       mov;
  } level_vec_t;

  level_vec_t lv[8];

  initial begin
    int          tq[$];
    int          cq[$];
    int          n, ups, dns, d;
    logic [1:0]  prev;

    lv[0] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1};
    lv[1] = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
    lv[2] = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0};
    lv[3] = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0};
    lv[4] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
    lv[5] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
    lv[6] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0};
    lv[7] = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b0};

    reset_n = 1'b0;
    mode = '0; invert = '0; up = '0; down = '0; delta_stb = '0; delta = '0;
    period_base = RATE_W'(4);
    model_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    check("reset dial_out", 32'(dial_out), 32'hF);
    check("reset moving", 32'(moving), 0);
    reset_n = 1'b1;
    tick();

    // Level mode vector table on channel 0.
    for (int i = 0; i < 8; i++) begin
      up[0] = lv[i].u; down[0] = lv[i].d; invert[0] = lv[i].inv;
      tick();
      check($sformatf("level vec%0d dial", i), 32'(dial_out[1:0]), 32'(lv[i].dial));
      check($sformatf("level vec%0d moving", i), 32'(moving[0]), 32'(lv[i].mov));
      check($sformatf("level vec%0d ch1 idle", i), 32'(dial_out[3:2]), 32'h3);
    end
    invert[0] = 1'b0;

    // Quadrature hold with acceleration on channel 1, period 4.
    mode[1] = 1'b1;
    tick(); tick();
    up[1] = 1'b1;
    prev = dial_out[3:2];
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dial_out[3:2] != prev) begin tq.push_back(k); cq.push_back(int'(dial_out[3:2])); end
      prev = dial_out[3:2];
    end
    check("hold step count", 32'(tq.size()), 13);
    for (int i = 0; i < 13 && i < tq.size(); i++) begin
      check($sformatf("hold step%0d time", i), 32'(tq[i]), 32'((i < 8) ? 4 * i : 28 + 2 * (i - 7)));
      check($sformatf("hold step%0d code", i), 32'(cq[i]), 32'(gray_tab[(i + 1) % 4]));
    end
    up[1] = 1'b0;
    repeat (5) tick();
    tq.delete();
    up[1] = 1'b1;
    prev = dial_out[3:2];
    for (int k = 0; k < 12; k++) begin
      tick();
      if (dial_out[3:2] != prev) tq.push_back(k);
      prev = dial_out[3:2];
    end
    check("repress step count", 32'(tq.size()), 3);
    for (int i = 0; i < 3 && i < tq.size(); i++)
      check($sformatf("repress step%0d time", i), 32'(tq[i]), 32'(4 * i));
    up[1] = 1'b0;
    tick();

    // Delta drain on channel 0, period 3.
    period_base = RATE_W'(3);
    mode[0] = 1'b1;
    tick(); tick();
    delta[7:0] = 8'd5; delta_stb[0] = 1'b1;
    tick();
    delta_stb[0] = 1'b0;
    tq.delete();
    prev = dial_out[1:0];
    for (int k = 0; k < 30; k++) begin
      tick();
      if (dial_out[1:0] != prev) tq.push_back(k);
      prev = dial_out[1:0];
    end
    check("drain +5 step count", 32'(tq.size()), 5);
    for (int i = 0; i < 5 && i < tq.size(); i++)
      check($sformatf("drain step%0d time", i), 32'(tq[i]), 32'(3 * i));
    check("drain +5 final code", 32'(dial_out[1:0]), 32'h2);
    check("drain +5 moving idle", 32'(moving[0]), 0);
    delta[7:0] = 8'hFE; delta_stb[0] = 1'b1;
    tick();
    delta_stb[0] = 1'b0;
    tq.delete(); cq.delete();
    prev = dial_out[1:0];
    for (int k = 0; k < 15; k++) begin
      tick();
      if (dial_out[1:0] != prev) begin tq.push_back(k); cq.push_back(int'(dial_out[1:0])); end
      prev = dial_out[1:0];
    end
    check("drain -2 step count", 32'(tq.size()), 2);
    if (cq.size() == 2) begin
      check("drain -2 first code", 32'(cq[0]), 32'h3);
      check("drain -2 wrap code", 32'(cq[1]), 32'h1);
    end

    // Saturation at +511, then strobe -128 with a concurrent drain: 382 left.
    period_base = RATE_W'(1);
    repeat (3) tick();
    delta[7:0] = 8'h7F; delta_stb[0] = 1'b1;
    repeat (5) tick();
    delta[7:0] = 8'h80;
    tick();
    delta_stb[0] = 1'b0;
    n = 0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (!moving[0]) break;
      n++;
    end
    check("saturated drain steps", 32'(n), 382);

    // Held direction has priority over the accumulator.
    period_base = RATE_W'(4);
    repeat (3) tick();
    delta[7:0] = 8'd10; delta_stb[0] = 1'b1; down[0] = 1'b1;
    ups = 0; dns = 0;
    prev = dial_out[1:0];
    for (int k = 0; k < 12; k++) begin
      tick();
      delta_stb[0] = 1'b0;
      d = (code_idx(dial_out[1:0]) - code_idx(prev) + 4) % 4;
      if (d == 1) ups++;
      if (d == 3) dns++;
      prev = dial_out[1:0];
    end
    check("priority down steps", 32'(dns), 3);
    check("priority no up steps", 32'(ups), 0);
    down[0] = 1'b0;
    ups = 0; dns = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      d = (code_idx(dial_out[1:0]) - code_idx(prev) + 4) % 4;
      if (d == 1) ups++;
      if (d == 3) dns++;
      prev = dial_out[1:0];
    end
    check("frozen acc drain ups", 32'(ups), 10);
    check("frozen acc drain downs", 32'(dns), 0);

    // Mode switch mid-hold clears the accumulator.
    delta[7:0] = 8'd10; delta_stb[0] = 1'b1; down[0] = 1'b1;
    tick();
    delta_stb[0] = 1'b0;
    tick();
    mode[0] = 1'b0;
    tick();
    check("mode switch level code", 32'(dial_out[1:0]), 32'h1);
    mode[0] = 1'b1; down[0] = 1'b0;
    tick();
    prev = dial_out[1:0];
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (dial_out[1:0] != prev || moving[0]) n++;
      prev = dial_out[1:0];
    end
    check("acc cleared by mode switch", 32'(n), 0);

    // Asynchronous reset mid-drain.
    period_base = RATE_W'(3);
    delta[7:0] = 8'd20; delta_stb[0] = 1'b1;
    tick();
    delta_stb[0] = 1'b0;
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset dial_out", 32'(dial_out), 32'hF);
    check("async reset moving", 32'(moving), 0);
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (moving != '0 || dial_out != 4'hF) n++;
    end
    check("no step after reset", 32'(n), 0);

    // Randomised stimulus against the model.
    mode = '1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 199) == 0) mode[c] = ~mode[c];
        if ($urandom_range(0, 299) == 0) invert[c] = ~invert[c];
        if ($urandom_range(0, 7) == 0) begin
          up[c]   = 1'($urandom_range(0, 1));
          down[c] = 1'($urandom_range(0, 1));
        end
        delta_stb[c] = ($urandom_range(0, 9) == 0);
        delta[c*DELTA_W +: DELTA_W] = DELTA_W'($urandom);
      end
      if ($urandom_range(0, 99) == 0) period_base = RATE_W'($urandom_range(0, 6));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
